// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: bench/decoder controls in, ROM address and run status out.
// With FETCH_CYCLE_COUNT_EN defined the bundle also carries the 16-bit CycleCt counter.
interface fetch_unit_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            Branch;
    logic            Zero;
    logic [7:0]      Offset;
    logic            Done;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
    logic            Halted;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]     CycleCt;
`endif

    modport master (
        output Start, Branch, Zero, Offset, Done,
`ifdef FETCH_CYCLE_COUNT_EN
        input  CycleCt,
`endif
        input  ProgCtr, Running, Halted
    );

    modport slave (
        input  Start, Branch, Zero, Offset, Done,
`ifdef FETCH_CYCLE_COUNT_EN
        output CycleCt,
`endif
        output ProgCtr, Running, Halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter / sequencer with an IDLE-RUN-HALT start handshake and zero-conditioned relative branches.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating count of the edges spent in RUN.
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}}
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_next_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] offset_ext_s;
    logic            running_r;
    logic            halted_r;

    // Sign-extend the 8-bit displacement; the add then wraps modulo 2^PC_W (PC_W must exceed 8).
    assign offset_ext_s = {{(PC_W-8){bus.Offset[7]}}, bus.Offset};

    // Next-state and next-PC selection; Start overrides every state.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        if (bus.Start) begin
            state_next_s = ST_IDLE;
            pc_next_s    = START_ADDR;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_RUN;
                    pc_next_s    = START_ADDR;
                end
                ST_RUN: begin
                    if (bus.Done) begin
                        state_next_s = ST_HALT;
                        pc_next_s    = pc_r;
                    end else if (bus.Branch && bus.Zero) begin
                        state_next_s = ST_RUN;
                        pc_next_s    = pc_r + offset_ext_s;
                    end else begin
                        state_next_s = ST_RUN;
                        pc_next_s    = pc_r + PC_ONE;
                    end
                end
                ST_HALT: begin
                    state_next_s = ST_HALT;
                    pc_next_s    = pc_r;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    pc_next_s    = START_ADDR;
                end
            endcase
        end
    end

    // State, PC and registered state decodes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= START_ADDR;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            running_r <= (state_next_s == ST_RUN);
            halted_r  <= (state_next_s == ST_HALT);
        end
    end

    assign bus.ProgCtr = pc_r;
    assign bus.Running = running_r;
    assign bus.Halted  = halted_r;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_ct_r;

    // Saturating count of edges taken while in RUN, including the edge into HALT.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycle_ct_r <= 16'h0000;
        end else if (bus.Start) begin
            cycle_ct_r <= 16'h0000;
        end else if ((state_r == ST_RUN) && (cycle_ct_r != 16'hFFFF)) begin
            cycle_ct_r <= cycle_ct_r + 16'h0001;
        end else begin
            cycle_ct_r <= cycle_ct_r;
        end
    end

    assign bus.CycleCt = cycle_ct_r;
`endif
endmodule
